// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: owns accumulators A/B and their carries, drives the
// data-RAM port, stalls fetch/decode while a load is outstanding and counts retirements.
module alu_writeback_stage #(
    parameter int RAM_READ_LATENCY = 1,
    parameter int RETIRE_WIDTH     = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iValid,
    input  logic [7:0]              iData,
    input  logic                    iWriteA,
    input  logic                    iWriteB,
    input  logic                    iCa,
    input  logic                    iCb,
    input  logic                    iReadA,
    input  logic                    iReadB,
    input  logic                    iRamEnableWrite,
    input  logic [9:0]              iRamAddress,
    input  logic [7:0]              iRamReadData,
    output logic [7:0]              oA,
    output logic [7:0]              oB,
    output logic                    oCa,
    output logic                    oCb,
    output logic [9:0]              oRamAddress,
    output logic [7:0]              oRamWriteData,
    output logic                    oRamWriteEnable,
    output logic                    oRamReadEnable,
    output logic                    oStall,
    output logic [RETIRE_WIDTH-1:0] oRetired
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [2:0]              LAT_LOAD = 3'(RAM_READ_LATENCY);
    localparam logic [RETIRE_WIDTH-1:0] ONE      = RETIRE_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [7:0]              a_q, a_d;
    logic [7:0]              b_q, b_d;
    logic                    ca_q, ca_d;
    logic                    cb_q, cb_d;
    logic                    load_b_q, load_b_d;
    logic [9:0]              addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

    always_comb begin
        // NOTE: every next-state variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        ca_d      = ca_q;
        cb_d      = cb_q;
        load_b_d  = load_b_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        retired_d = retired_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    if (iReadA || iReadB) begin
                        // Load wins over everything else in the same instruction.
                        load_b_d = !iReadA;
                        addr_d   = iRamAddress;
                        rd_en_d  = 1'b1;
                        cnt_d    = LAT_LOAD;
                        state_d  = ST_WAIT;
                    end else if (iRamEnableWrite) begin
                        addr_d    = iRamAddress;
                        wdata_d   = iData;
                        wr_en_d   = 1'b1;
                        retired_d = retired_q + ONE;
                    end else begin
                        if (iWriteA) begin
                            a_d  = iData;
                            ca_d = iCa;
                        end
                        if (iWriteB) begin
                            b_d  = iData;
                            cb_d = iCb;
                        end
                        retired_d = retired_q + ONE;
                    end
                end
            end
            ST_WAIT: begin
                // Counter reaches zero in exactly the cycle the RAM data is valid.
                if (cnt_q == 3'd0) begin
                    if (load_b_q) b_d = iRamReadData;
                    else          a_d = iRamReadData;
                    retired_d = retired_q + ONE;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            ca_q      <= 1'b0;
            cb_q      <= 1'b0;
            load_b_q  <= 1'b0;
            addr_q    <= 10'd0;
            wdata_q   <= 8'd0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ca_q      <= ca_d;
            cb_q      <= cb_d;
            load_b_q  <= load_b_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            retired_q <= retired_d;
        end
    end

    assign oA              = a_q;
    assign oB              = b_q;
    assign oCa             = ca_q;
    assign oCb             = cb_q;
    assign oRamAddress     = addr_q;
    assign oRamWriteData   = wdata_q;
    assign oRamWriteEnable = wr_en_q;
    assign oRamReadEnable  = rd_en_q;
    assign oStall          = (state_q == ST_WAIT);
    assign oRetired        = retired_q;

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU's per-instruction control and result outputs.
- Owns architectural accumulators A and B and carry flags Ca and Cb, which are fed back to the ALU operand inputs.
- Drives the data-RAM port, sequences multi-cycle loads with a stall handshake toward fetch/decode, and counts retired instructions.

Parameters:
- RAM_READ_LATENCY, 1: cycles from the oRamReadEnable cycle to the iRamReadData valid cycle; legal range 1..7.
- RETIRE_WIDTH, 16: width of the retired-instruction counter.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iValid  in  1  ALU outputs in this cycle carry a real instruction.
- iData  in  8  ALU result (ADD/SUB/logic/shift result, or A/B for STA/STB and LDCA/LDCB).
- iWriteA  in  1  write iData to A.
- iWriteB  in  1  write iData to B.
- iCa  in  1  carry for A, taken with iWriteA.
- iCb  in  1  carry for B, taken with iWriteB.
- iReadA  in  1  load A from RAM[iRamAddress].
- iReadB  in  1  load B from RAM[iRamAddress].
- iRamEnableWrite  in  1  store iData to RAM[iRamAddress].
- iRamAddress  in  10  RAM address for load/store.
- iRamReadData  in  8  RAM read data.
- oA  out  8  accumulator A (to ALU iA).
- oB  out  8  accumulator B (to ALU iB).
- oCa  out  1  carry flag A.
- oCb  out  1  carry flag B.
- oRamAddress  out  10  registered RAM address.
- oRamWriteData  out  8  registered store data.
- oRamWriteEnable  out  1  one-cycle store strobe.
- oRamReadEnable  out  1  one-cycle load strobe.
- oStall  out  1  upstream must hold its current instruction.
- oRetired  out  RETIRE_WIDTH  count of retired instructions.

Behaviour:
- Reset: all outputs 0; A=B=0; Ca=Cb=0; state IDLE; latency counter 0. Reset overrides everything, including aborting a load in progress with no capture.
- Instruction acceptance: only in IDLE with iValid=1. oStall=0 in IDLE. In WAIT, all inputs except iRamReadData are ignored.
- Priority when several controls are high: iReadA > iReadB > iRamEnableWrite > iWriteA/iWriteB. Lower-priority controls of the same instruction are dropped. iWriteA and iWriteB may both be high and both update.
- Register write, accepted with iWriteA: A<=iData and Ca<=iCa next edge. iWriteB likewise updates B and Cb. The carry flag of the non-written register is unchanged. Retires the instruction: oRetired+1.
- Store, accepted in cycle t: during t+1, oRamWriteEnable=1, oRamAddress=iRamAddress(t), oRamWriteData=iData(t). oRamWriteEnable=0 otherwise. Retires. No stall.
- Load, accepted in cycle t:
  - During t+1: oRamReadEnable=1 (single cycle), oRamAddress=iRamAddress(t), oStall=1, state WAIT, counter=RAM_READ_LATENCY.
  - Counter decrements each WAIT cycle. iRamReadData is valid in cycle t+1+RAM_READ_LATENCY and is captured into A (iReadA) or B (iReadB) at the end of that cycle.
  - The loaded register's carry flag is unchanged.
  - Next state IDLE with oStall=0 from cycle t+2+RAM_READ_LATENCY; oRetired increments at the capture edge.
  - Total stall = RAM_READ_LATENCY+1 cycles.
- Back-to-back load after load: the held instruction is accepted in the first IDLE cycle, so the load strobe spacing is RAM_READ_LATENCY+2 cycles.
- Store followed by load to the same address: the store strobe precedes the load strobe by at least one cycle. The RAM returns the new data; no bypass is needed in this block.
- NOP (iValid=1, all controls 0; covers branches): retires with no other effect.
- iValid=0: nothing changes.
- oRamAddress holds its last value when no strobe is active.
- oRetired wraps from all-ones to 0.
- No bypass: oA/oB change one edge after a write. The ALU sees the new value on the next instruction, matching single-issue timing.

Test Plan:
- Reset, then iValid=1, iWriteA=1, iData=0x3C, iCa=1 -> next cycle oA=0x3C, oCa=1, oCb=0, oB=0, oRetired=1.
- Store: iRamEnableWrite=1, iRamAddress=0x155, iData=0xA5 -> one cycle later oRamWriteEnable=1, oRamAddress=0x155, oRamWriteData=0xA5; strobe low the following cycle; oStall never high.
- Load B, RAM_READ_LATENCY=2: iReadB=1, iRamAddress=0x010 at cycle t -> oRamReadEnable=1 only in t+1; oStall=1 for t+1..t+3; iRamReadData=0x7E in t+3 -> oB=0x7E and oStall=0 in t+4; oCb unchanged.
- Stall hold: present iWriteA with iData=0x11 during the load stall -> ignored; accepted once oStall=0 -> oA=0x11 one cycle later; oRetired advances by exactly 2 across the sequence.
- Reset asserted in the cycle after a load is accepted -> next cycle oStall=0, oA=oB=0, no capture; stale iRamReadData afterwards has no effect.
- Conflict: iReadA=1 and iWriteA=1 with iData=0xFF, RAM returns 0x01 -> oA=0x01, never 0xFF. Also preset oRetired=all-ones via writes and retire one more NOP -> oRetired=0.
